// File: rtl/vga_pkg.sv
// Shared timing constants, pipeline sideband type and pixel colour expansion
// for the VGA scan-out path (default geometry: 640x480@60, 25 MHz pixel clock).
// No ports; imported by vga_timing and vga_controller.
package vga_pkg;

  // Default 640x480@60 geometry, horizontal in pixel clocks, vertical in lines
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;  // 800
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;  // 525

  localparam int DEF_PIXEL_DEPTH = 8;

  // Per-pixel sideband decoded at S0 and carried alongside the colour data.
  // Sync bits are positive-true here; pin polarity is applied at the output.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } vga_ctl_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // RGB332 -> RGB444: replicate the MSBs into the missing low bits so that
  // full-scale inputs map to full-scale outputs (7 -> F, 3 -> F).
  function automatic rgb444_t rgb332_to_rgb444(input logic [7:0] p);
    rgb444_t c;
    c.r = {p[7:5], p[7]};
    c.g = {p[4:2], p[4]};
    c.b = {p[1:0], p[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters plus S0 decode of active, sync, frame start and vblank.
// Latency: decode is combinational from the counter registers (S0). Free-running, no backpressure.
// Ports: i_pxclk/i_rst clock and async active-high reset; o_h_cnt/o_v_cnt raw counters;
//        o_ctl active+sync sideband; o_frame_start one-cycle pulse at (0,0); o_vblank for v >= visible.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int H_W      = $clog2(H_TOTAL),
  localparam int V_W      = $clog2(V_TOTAL)
) (
  input  logic           i_pxclk,
  input  logic           i_rst,
  output logic [H_W-1:0] o_h_cnt,
  output logic [V_W-1:0] o_v_cnt,
  output vga_ctl_t       o_ctl,
  output logic           o_frame_start,
  output logic           o_vblank
);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] HS_START   = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0] HS_END     = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] VS_START   = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0] VS_END     = V_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;

  always_ff @(posedge i_pxclk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  always_comb begin
    o_ctl        = '0;
    o_ctl.active = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    o_ctl.hsync  = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    o_ctl.vsync  = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
  end

  // Counters already sit at (0,0) while reset is held; mask the pulse so it
  // only appears once the scan is actually running.
  assign o_frame_start = ~i_rst && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_vblank      = (r_v_cnt >= V_ACT_END);

  assign o_h_cnt = r_h_cnt;
  assign o_v_cnt = r_v_cnt;

endmodule

// File: rtl/vga_controller.sv
// VGA scan-out: walks the frame buffer pixel port and drives RGB444 + sync pins.
// Latency: pins lag the S0 counters by 2 cycles (1 RAM read + 1 output register). No backpressure.
// Ports: pxclk/rst pixel clock and async active-high reset; px_addr/px_data frame buffer read port
//        (data one cycle after address); vga_r/g/b/hs/vs board pins; frame_start/vblank S0 status.
module vga_controller
  import vga_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter int PIXEL_DEPTH     = DEF_PIXEL_DEPTH,
  parameter int SYNC_ACTIVE_LOW = 1,
  localparam int PIXEL_ADDR_WIDTH = $clog2(H_VISIBLE * V_VISIBLE)
) (
  input  logic                        pxclk,
  input  logic                        rst,
  output logic [PIXEL_ADDR_WIDTH-1:0] px_addr,
  input  logic [PIXEL_DEPTH-1:0]      px_data,
  output logic [3:0]                  vga_r,
  output logic [3:0]                  vga_g,
  output logic [3:0]                  vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic                        frame_start,
  output logic                        vblank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_LAST_PIX  = H_W'(H_VISIBLE - 1);
  localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST_LINE = V_W'(V_VISIBLE - 1);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  logic [H_W-1:0] w_h_cnt;
  logic [V_W-1:0] w_v_cnt;
  vga_ctl_t       w_ctl;
  logic           w_frame_end;
  logic           w_next_line_active;
  logic           w_addr_adv;
  rgb444_t        w_pix;

  logic [PIXEL_ADDR_WIDTH-1:0] r_px_addr;
  vga_ctl_t                    r_d1;
  rgb444_t                     r_rgb;
  logic                        r_hs;
  logic                        r_vs;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .i_pxclk       (pxclk),
    .i_rst         (rst),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_ctl         (w_ctl),
    .o_frame_start (frame_start),
    .o_vblank      (vblank)
  );

  // S0 address counter. It always holds the address of the current pixel, or
  // of the last pixel shown while blanking, so the step into the next line is
  // taken on the final cycle of the preceding line rather than at end of line.
  assign w_frame_end        = (w_h_cnt == H_LAST) && (w_v_cnt == V_LAST);
  assign w_next_line_active = (w_h_cnt == H_LAST) && (w_v_cnt < V_LAST_LINE);
  assign w_addr_adv         = (w_ctl.active && (w_h_cnt != H_LAST_PIX)) || w_next_line_active;

  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) begin
      r_px_addr <= '0;
    end else if (w_frame_end) begin
      r_px_addr <= '0;
    end else if (w_addr_adv) begin
      r_px_addr <= r_px_addr + 1'b1;
    end
  end

  assign px_addr = r_px_addr;

  // S1: sideband waits here while the RAM turns px_addr into px_data.
  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) begin
      r_d1 <= '0;
    end else begin
      r_d1 <= w_ctl;
    end
  end

  // S2: output registers. Colour is blanked from the delayed active bit so
  // whatever the RAM returns outside the visible window never reaches the pins.
  assign w_pix = rgb332_to_rgb444(px_data);

  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) begin
      r_rgb <= '0;
      r_hs  <= SYNC_IDLE;
      r_vs  <= SYNC_IDLE;
    end else begin
      r_rgb <= r_d1.active ? w_pix : '0;
      r_hs  <= r_d1.hsync ? ~SYNC_IDLE : SYNC_IDLE;
      r_vs  <= r_d1.vsync ? ~SYNC_IDLE : SYNC_IDLE;
    end
  end

  assign vga_r  = r_rgb.r;
  assign vga_g  = r_rgb.g;
  assign vga_b  = r_rgb.b;
  assign vga_hs = r_hs;
  assign vga_vs = r_vs;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller with a reduced timing geometry so several whole
// frames fit in a short run. A registered RAM model answers px_addr; expected
// pin values are queued at S0 time and popped when they reach the pins.
module tb_vga_controller;

  localparam int HV  = 16;
  localparam int HF  = 4;
  localparam int HSW = 6;
  localparam int HB  = 4;
  localparam int HT  = HV + HF + HSW + HB;   // 30
  localparam int VV  = 12;
  localparam int VF  = 2;
  localparam int VSW = 2;
  localparam int VB  = 3;
  localparam int VT  = VV + VF + VSW + VB;   // 19
  localparam int FRAME = HT * VT;            // 570
  localparam int AW  = $clog2(HV * VV);      // 8

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } pins_t;

  logic          pxclk;
  logic          rst;
  logic [AW-1:0] px_addr;
  logic [7:0]    px_data;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, frame_start, vblank;

  int    checks = 0;
  int    errors = 0;
  int    ram_mode = 0;
  int    mh = 0;
  int    mv = 0;
  pins_t sbq[$];

  vga_controller #(
    .H_VISIBLE       (HV),
    .H_FRONT         (HF),
    .H_SYNC          (HSW),
    .H_BACK          (HB),
    .V_VISIBLE       (VV),
    .V_FRONT         (VF),
    .V_SYNC          (VSW),
    .V_BACK          (VB),
    .PIXEL_DEPTH     (8),
    .SYNC_ACTIVE_LOW (1)
  ) dut (
    .pxclk       (pxclk),
    .rst         (rst),
    .px_addr     (px_addr),
    .px_data     (px_data),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start),
    .vblank      (vblank)
  );

  initial begin
    pxclk = 1'b0;
    forever #5 pxclk = ~pxclk;
  end

  // RAM contents by mode: 0 address pattern, 1 all 0xFF, 2 E0/1F at 0/1, 3 random
  function automatic logic [7:0] ram_word(input int a);
    logic [7:0] w;
    int t;
    case (ram_mode)
      1: w = 8'hFF;
      2: w = (a == 0) ? 8'hE0 : ((a == 1) ? 8'h1F : 8'h00);
      3: w = 8'($urandom);
      default: begin
        t = a * 37 + 11;
        w = t[7:0];
      end
    endcase
    return w;
  endfunction

  always @(posedge pxclk) px_data <= ram_word(int'(px_addr));

  // Address expected at S0 position (h,v): current pixel, or last shown pixel in blanking
  function automatic int model_addr(input int h, input int v);
    if (v >= VV) return VV * HV - 1;
    if (h >= HV) return v * HV + HV - 1;
    return v * HV + h;
  endfunction

  function automatic pins_t model_pins(input int h, input int v);
    pins_t e;
    logic [7:0] p;
    e = '0;
    if (h < HV && v < VV) begin
      p = ram_word(model_addr(h, v));
      e.r = {p[7:5], p[7]};
      e.g = {p[4:2], p[4]};
      e.b = {p[1:0], p[1:0]};
    end
    e.hs = !(h >= HV + HF && h < HV + HF + HSW);
    e.vs = !(v >= VV + VF && v < VV + VF + VSW);
    return e;
  endfunction

  task automatic hold_reset(input int n);
    @(negedge pxclk);
    rst = 1'b1;
    repeat (n) @(negedge pxclk);
  endtask

  // Release reset and sync the model: S0 is at (0,0), pins still show two idle cycles
  task automatic release_reset();
    pins_t idle;
    @(negedge pxclk);
    rst = 1'b0;
    #1;
    mh = 0;
    mv = 0;
    idle = '0;
    idle.hs = 1'b1;
    idle.vs = 1'b1;
    sbq.delete();
    sbq.push_back(idle);
    sbq.push_back(idle);
  endtask

  task automatic advance();
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    @(negedge pxclk);
    #1;
  endtask

  task automatic test_reset();
    ram_mode = 3;
    for (int c = 0; c < 6; c++) begin
      @(negedge pxclk);
      #1;
      checks++;
      if ({vga_r, vga_g, vga_b} !== 12'h000) begin
        errors++;
        $display("FAIL reset_rgb got=%h exp=000", {vga_r, vga_g, vga_b});
      end
      checks++;
      if ({vga_hs, vga_vs} !== 2'b11) begin
        errors++;
        $display("FAIL reset_sync got=%b exp=11", {vga_hs, vga_vs});
      end
      checks++;
      if (px_addr !== '0 || frame_start !== 1'b0 || vblank !== 1'b0) begin
        errors++;
        $display("FAIL reset_state addr=%0d fs=%b vb=%b exp 0/0/0", px_addr, frame_start, vblank);
      end
    end
    release_reset();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_frame_start got=%b exp=1", frame_start);
    end
  endtask

  // Scoreboard scan: every cycle checks S0 outputs and pops the pin values queued 2 cycles earlier
  task automatic test_scan(input int ncycles, input string tag);
    pins_t got;
    pins_t exp;
    for (int c = 0; c < ncycles; c++) begin
      checks++;
      if (px_addr !== AW'(model_addr(mh, mv))) begin
        errors++;
        $display("FAIL %s px_addr h=%0d v=%0d got=%0d exp=%0d", tag, mh, mv, px_addr, model_addr(mh, mv));
      end
      checks++;
      if (frame_start !== (mh == 0 && mv == 0)) begin
        errors++;
        $display("FAIL %s frame_start h=%0d v=%0d got=%b", tag, mh, mv, frame_start);
      end
      checks++;
      if (vblank !== (mv >= VV)) begin
        errors++;
        $display("FAIL %s vblank h=%0d v=%0d got=%b", tag, mh, mv, vblank);
      end
      sbq.push_back(model_pins(mh, mv));
      exp = sbq.pop_front();
      got = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s pins h=%0d v=%0d got=%h exp=%h", tag, mh, mv, got, exp);
      end
      advance();
    end
  endtask

  task automatic test_pixel_colour();
    logic [11:0] exp_rgb[5];
    exp_rgb = '{12'h000, 12'h000, 12'hF00, 12'h0FF, 12'h000};
    ram_mode = 2;
    hold_reset(2);
    release_reset();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb[c]) begin
        errors++;
        $display("FAIL colour cycle=%0d got=%h exp=%h", c, {vga_r, vga_g, vga_b}, exp_rgb[c]);
      end
      @(negedge pxclk);
      #1;
    end
  endtask

  task automatic test_line_timing();
    int   exp_fall[$];
    int   last_fall;
    logic prev;
    ram_mode = 0;
    hold_reset(2);
    release_reset();
    exp_fall = '{HV + HF + 2, HV + HF + 2 + HT};
    last_fall = -1;
    prev = vga_hs;
    for (int c = 0; c < 2 * HT + HSW + 6; c++) begin
      if (prev === 1'b1 && vga_hs === 1'b0) begin
        checks++;
        if (exp_fall.size() == 0) begin
          errors++;
          $display("FAIL hs_fall unexpected at cycle=%0d", c);
        end else if (c != exp_fall[0]) begin
          errors++;
          $display("FAIL hs_fall got=%0d exp=%0d", c, exp_fall[0]);
        end
        if (exp_fall.size() != 0) void'(exp_fall.pop_front());
        last_fall = c;
      end
      if (prev === 1'b0 && vga_hs === 1'b1 && last_fall >= 0) begin
        checks++;
        if (c - last_fall != HSW) begin
          errors++;
          $display("FAIL hs_width got=%0d exp=%0d", c - last_fall, HSW);
        end
      end
      prev = vga_hs;
      @(negedge pxclk);
      #1;
    end
    checks++;
    if (exp_fall.size() != 0) begin
      errors++;
      $display("FAIL hs_fall missing got=%0d_left exp=0", exp_fall.size());
    end
  endtask

  task automatic test_address_sequence();
    ram_mode = 0;
    hold_reset(2);
    release_reset();
    test_scan(2 * FRAME + 5, "addr");
  endtask

  task automatic test_blanking();
    int vs_low;
    int vs_first;
    int lit;
    ram_mode = 1;
    hold_reset(2);
    release_reset();
    vs_low = 0;
    vs_first = -1;
    lit = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (vga_vs === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = c;
      end
      if ({vga_r, vga_g, vga_b} !== 12'h000) lit++;
      @(negedge pxclk);
      #1;
    end
    checks++;
    if (vs_first != (VV + VF) * HT + 2) begin
      errors++;
      $display("FAIL vs_start got=%0d exp=%0d", vs_first, (VV + VF) * HT + 2);
    end
    checks++;
    if (vs_low != VSW * HT) begin
      errors++;
      $display("FAIL vs_cycles got=%0d exp=%0d", vs_low, VSW * HT);
    end
    checks++;
    if (lit != HV * VV) begin
      errors++;
      $display("FAIL lit_cycles got=%0d exp=%0d", lit, HV * VV);
    end
    hold_reset(2);
    release_reset();
    test_scan(FRAME + 2 * HT, "blank");
  endtask

  task automatic test_mid_frame_reset();
    int pos_h[2];
    int pos_v[2];
    pos_h = '{9, 23};
    pos_v = '{7, 14};
    for (int k = 0; k < 2; k++) begin
      ram_mode = 0;
      hold_reset(2);
      release_reset();
      repeat (pos_v[k] * HT + pos_h[k]) advance();
      checks++;
      if (px_addr !== AW'(model_addr(mh, mv))) begin
        errors++;
        $display("FAIL midrst_pre_addr got=%0d exp=%0d", px_addr, model_addr(mh, mv));
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== 14'b0000_0000_0000_11) begin
        errors++;
        $display("FAIL midrst_pins got=%h exp=%h", {vga_r, vga_g, vga_b, vga_hs, vga_vs}, 14'b0000_0000_0000_11);
      end
      checks++;
      if (px_addr !== '0 || frame_start !== 1'b0 || vblank !== 1'b0) begin
        errors++;
        $display("FAIL midrst_state addr=%0d fs=%b vb=%b exp 0/0/0", px_addr, frame_start, vblank);
      end
      repeat (2) @(negedge pxclk);
      release_reset();
      checks++;
      if (frame_start !== 1'b1 || px_addr !== '0) begin
        errors++;
        $display("FAIL midrst_restart fs=%b addr=%0d exp 1/0", frame_start, px_addr);
      end
      test_scan(3 * HT, "restart");
    end
  endtask

  task automatic test_back_to_back();
    int expq[$];
    ram_mode = 0;
    hold_reset(2);
    release_reset();
    expq = '{0, FRAME, 2 * FRAME};
    for (int c = 0; c < 2 * FRAME + 20; c++) begin
      if (frame_start === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL frame_period unexpected pulse at cycle=%0d", c);
        end else begin
          if (c != expq[0]) begin
            errors++;
            $display("FAIL frame_period got=%0d exp=%0d", c, expq[0]);
          end
          void'(expq.pop_front());
        end
      end
      @(negedge pxclk);
      #1;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL frame_period missing got=%0d_left exp=0", expq.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    ram_mode = 3;
    #2 rst = 1'b1;
    test_reset();
    test_pixel_colour();
    test_line_timing();
    test_address_sequence();
    test_blanking();
    test_mid_frame_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
